reg_dest_scoreboard: RTL and testbench

- Decode-side counterpart of the 5-bit register-address select path.
- Accepts the already-selected 5-bit destination register address at issue and tracks outstanding writes per architectural register.
- At writeback, decodes the 5-bit address back into a registered one-hot register-file write enable and retires the pending write.
- Answers source-operand hazard queries for the two read ports.
- Sits between the destination-address select and the register file in the KGP-RISC datapath.

---
 rtl/reg_dest_scoreboard.sv | 77 +++++++
 tb/tb_reg_dest_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard: tracks outstanding writes per architectural
// register, flags source hazards, and produces the one-hot register-file write enable.
module reg_dest_scoreboard #(
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_dest,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_dest,
  output logic [NREG-1:0] wb_we_onehot,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  output logic            rs_busy,
  output logic            rt_busy,
  output logic [AW:0]     pend_count,
  output logic            wb_err
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] wb_we_q, wb_we_d;
  logic [AW:0]     pend_count_q, pend_count_d;
  logic            wb_err_q, wb_err_d;

  logic wb_hit;
  logic iss_set;
  logic wb_clr;

  assign wb_hit  = wb_valid & (wb_dest != '0);
  // A retiring write to the same register frees the slot in the same cycle.
  assign iss_ready = ~pending_q[iss_dest] | (wb_hit & (wb_dest == iss_dest));
  assign iss_set   = iss_valid & iss_ready & (iss_dest != '0);
  assign wb_clr    = wb_hit & pending_q[wb_dest];

  assign rs_busy = pending_q[rs_addr] & ~(wb_hit & (wb_dest == rs_addr));
  assign rt_busy = pending_q[rt_addr] & ~(wb_hit & (wb_dest == rt_addr));

  always_comb begin
    pending_d = pending_q;
    if (wb_hit) pending_d[wb_dest] = 1'b0;
    if (iss_set) pending_d[iss_dest] = 1'b1;
  end

  always_comb begin
    wb_we_d = '0;
    if (wb_hit) wb_we_d[wb_dest] = 1'b1;
  end

  // Clear-then-set on the same register nets to zero: +1 and -1 cancel.
  always_comb begin
    pend_count_d = pend_count_q + (AW+1)'(iss_set) - (AW+1)'(wb_clr);
  end

  assign wb_err_d = wb_err_q | (wb_hit & ~pending_q[wb_dest]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      wb_we_q      <= '0;
      pend_count_q <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      wb_we_q      <= wb_we_d;
      pend_count_q <= pend_count_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign wb_we_onehot = wb_we_q;
  assign pend_count   = pend_count_q;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard: hand-computed expectations checked
// with immediate assertions.
module tb_reg_dest_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_we_onehot;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [5:0]  pend_count;
  logic        wb_err;

  int tests_run;
  int tests_failed;

  reg_dest_scoreboard #(.AW(5), .NREG(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_dest     (iss_dest),
    .iss_ready    (iss_ready),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_we_onehot (wb_we_onehot),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy),
    .pend_count   (pend_count),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    iss_valid = 1'b0; iss_dest = 5'd0;
    wb_valid = 1'b0;  wb_dest = 5'd0;
    rs_addr = 5'd0;   rt_addr = 5'd0;
    step();
    step();
    rst = 1'b0;
    iss_dest = 5'd5;
    #1;
    chk("idle_pend_count", pend_count, 0);
    chk("idle_wb_we", wb_we_onehot, 0);
    chk("idle_rs_busy", rs_busy, 0);
    chk("idle_rt_busy", rt_busy, 0);
    chk("idle_iss_ready", iss_ready, 1);
    chk("idle_wb_err", wb_err, 0);

    // issue 5, then probe hazards
    iss_valid = 1'b1; iss_dest = 5'd5;
    step();
    rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    chk("p5_rs_busy", rs_busy, 1);
    chk("p5_rt_busy", rt_busy, 1);
    chk("p5_pend_count", pend_count, 1);
    chk("p5_waw_stall", iss_ready, 0);
    iss_valid = 1'b0;
    step();
    chk("p5_stall_no_effect", pend_count, 1);

    // writeback 5: forwarded combinationally
    wb_valid = 1'b1; wb_dest = 5'd5;
    #1;
    chk("wb5_rs_fwd", rs_busy, 0);
    chk("wb5_rt_fwd", rt_busy, 0);
    chk("wb5_iss_ready", iss_ready, 1);
    step();
    wb_valid = 1'b0;
    #1;
    chk("wb5_onehot", wb_we_onehot, 32'h0000_0020);
    chk("wb5_pend_count", pend_count, 0);
    chk("wb5_rs_idle", rs_busy, 0);
    step();
    chk("wb_idle_onehot", wb_we_onehot, 0);

    // pending 7, then issue and writeback 7 in the same cycle
    iss_valid = 1'b1; iss_dest = 5'd7;
    step();
    iss_valid = 1'b0;
    #1;
    chk("p7_pend_count", pend_count, 1);
    iss_valid = 1'b1; iss_dest = 5'd7;
    wb_valid = 1'b1;  wb_dest = 5'd7;
    #1;
    chk("same7_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0; wb_valid = 1'b0;
    rs_addr = 5'd7;
    #1;
    chk("same7_pend_count", pend_count, 1);
    chk("same7_onehot", wb_we_onehot, 32'h0000_0080);
    chk("same7_still_busy", rs_busy, 1);
    chk("same7_no_err", wb_err, 0);
    wb_valid = 1'b1; wb_dest = 5'd7;
    step();
    wb_valid = 1'b0;
    #1;
    chk("ret7_pend_count", pend_count, 0);

    // register 0 is hardwired
    iss_valid = 1'b1; iss_dest = 5'd0;
    wb_valid = 1'b1;  wb_dest = 5'd0;
    rs_addr = 5'd0;   rt_addr = 5'd0;
    #1;
    chk("r0_iss_ready", iss_ready, 1);
    chk("r0_rs_busy", rs_busy, 0);
    step();
    iss_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("r0_onehot", wb_we_onehot, 0);
    chk("r0_wb_err", wb_err, 0);
    chk("r0_pend_count", pend_count, 0);
    chk("r0_rt_busy", rt_busy, 0);

    // erroneous writeback to non-pending 9
    wb_valid = 1'b1; wb_dest = 5'd9;
    step();
    wb_valid = 1'b0;
    #1;
    chk("err9_wb_err", wb_err, 1);
    chk("err9_pend_count", pend_count, 0);
    chk("err9_onehot", wb_we_onehot, 32'h0000_0200);

    // issue 3 then fill every register; 3 stalls on its second attempt
    iss_valid = 1'b1; iss_dest = 5'd3;
    step();
    chk("i3_pend_count", pend_count, 1);
    for (int r = 1; r < 32; r++) begin
      iss_dest = 5'(r);
      step();
    end
    iss_valid = 1'b0;
    iss_dest = 5'd10; rs_addr = 5'd31; rt_addr = 5'd1;
    #1;
    chk("full_pend_count", pend_count, 31);
    chk("full_iss_ready", iss_ready, 0);
    chk("full_rs_busy", rs_busy, 1);
    chk("full_rt_busy", rt_busy, 1);
    chk("full_wb_err_sticky", wb_err, 1);

    // retire 31 alone: count drops by one
    wb_valid = 1'b1; wb_dest = 5'd31;
    step();
    wb_valid = 1'b0;
    #1;
    chk("ret31_pend_count", pend_count, 30);
    chk("ret31_onehot", wb_we_onehot, 32'h8000_0000);

    // reset mid-operation with traffic present
    rst = 1'b1;
    wb_valid = 1'b1; wb_dest = 5'd4;
    iss_valid = 1'b1; iss_dest = 5'd6;
    step();
    rst = 1'b0;
    wb_valid = 1'b0; iss_valid = 1'b0;
    rs_addr = 5'd6; rt_addr = 5'd4; iss_dest = 5'd4;
    #1;
    chk("rst_pend_count", pend_count, 0);
    chk("rst_onehot", wb_we_onehot, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_rs_busy", rs_busy, 0);
    chk("rst_rt_busy", rt_busy, 0);
    chk("rst_iss_ready", iss_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
